// File: rtl/store_narrow_unit.sv
// Store-side narrowing: encodes byte/half/word stores into lane-replicated data
// with byte enables, queued in a DEPTH-entry FIFO between EX/MEM and data memory.
module store_narrow_unit #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_wdata,
    input  logic [1:0]        s_size,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_be,
    output logic              m_lossy,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
        logic              lossy;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              err_valid_q;
    logic [ADDR_W-1:0] err_addr_q;

    entry_t enc_s;
    logic   reject_s;
    logic   accept_s;
    logic   push_s;
    logic   pop_s;

    // True when the bits above the kept field are not a pure sign extension.
    function automatic logic not_sign_ext(input logic [31:0] d, input int msb);
        logic all_zero;
        logic all_one;
        all_zero = 1'b1;
        all_one  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb) begin
                all_zero = all_zero & ~d[i];
                all_one  = all_one & d[i];
            end
        end
        return !(all_zero || all_one);
    endfunction

    assign s_ready  = (count_q != FULL_C);
    assign m_valid  = (count_q != {CNT_W{1'b0}});
    assign accept_s = s_valid && s_ready;
    assign push_s   = accept_s && !reject_s;
    assign pop_s    = m_valid && m_ready;

    assign m_addr    = mem_q[rd_ptr_q].addr;
    assign m_wdata   = mem_q[rd_ptr_q].data;
    assign m_be      = mem_q[rd_ptr_q].be;
    assign m_lossy   = mem_q[rd_ptr_q].lossy;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    // Encode the incoming request and classify misaligned/illegal sizes.
    always_comb begin
        enc_s      = '0;
        reject_s   = 1'b0;
        enc_s.addr = {s_addr[ADDR_W-1:2], 2'b00};
        case (s_size)
            2'b00: begin
                enc_s.data  = {4{s_wdata[7:0]}};
                enc_s.be    = 4'b0001 << s_addr[1:0];
                enc_s.lossy = not_sign_ext(s_wdata, 7);
            end
            2'b01: begin
                enc_s.data  = {2{s_wdata[15:0]}};
                enc_s.be    = s_addr[1] ? 4'b1100 : 4'b0011;
                enc_s.lossy = not_sign_ext(s_wdata, 15);
                reject_s    = s_addr[0];
            end
            2'b10: begin
                enc_s.data  = s_wdata;
                enc_s.be    = 4'b1111;
                enc_s.lossy = 1'b0;
                reject_s    = (s_addr[1:0] != 2'b00);
            end
            default: begin
                reject_s = 1'b1;
            end
        endcase
    end

    // Occupancy next state; a rejected push alongside a pop still drains.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and reject reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= enc_s;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            err_valid_q <= accept_s && reject_s;
            if (accept_s && reject_s) begin
                err_addr_q <= s_addr;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: encoding table, backpressure and async reset.
module tb_store_narrow_unit;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_size;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_lossy;
    logic        err_valid;
    logic [31:0] err_addr;

    int pass_cnt = 0;
    int total_cnt = 0;

    store_narrow_unit #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_size(s_size),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_lossy(m_lossy),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_lossy;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz);
        s_valid = v;
        s_addr  = a;
        s_wdata = d;
        s_size  = sz;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] a, input logic [31:0] d);
        chk({nm, "_mvalid"}, {31'd0, m_valid}, 32'd1);
        chk({nm, "_maddr"}, m_addr, a);
        chk({nm, "_mwdata"}, m_wdata, d);
        chk({nm, "_mbe"}, {28'd0, m_be}, 32'h0000000F);
    endtask

    logic [31:0] last_err;

    initial begin
        vec[0]  = '{32'h00001003, 32'hFFFFFF80, 2'b00, 1'b0, 32'h00001000, 32'h80808080, 4'b1000, 1'b0};
        vec[1]  = '{32'h00002002, 32'h00012345, 2'b01, 1'b0, 32'h00002000, 32'h23452345, 4'b1100, 1'b1};
        vec[2]  = '{32'h00003001, 32'h11111111, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0000, 1'b0};
        vec[3]  = '{32'h00000040, 32'h22222222, 2'b11, 1'b1, 32'h0, 32'h0, 4'b0000, 1'b0};
        vec[4]  = '{32'h00000501, 32'h0000007F, 2'b00, 1'b0, 32'h00000500, 32'h7F7F7F7F, 4'b0010, 1'b0};
        vec[5]  = '{32'h00000602, 32'h00000080, 2'b00, 1'b0, 32'h00000600, 32'h80808080, 4'b0100, 1'b1};
        vec[6]  = '{32'h00000700, 32'hFFFF8000, 2'b01, 1'b0, 32'h00000700, 32'h80008000, 4'b0011, 1'b0};
        vec[7]  = '{32'h00000704, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00000704, 32'hDEADBEEF, 4'b1111, 1'b0};
        vec[8]  = '{32'h00000803, 32'h00001234, 2'b01, 1'b1, 32'h0, 32'h0, 4'b0000, 1'b0};
        vec[9]  = '{32'h00000902, 32'h00005678, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0000, 1'b0};
        vec[10] = '{32'h00000A01, 32'h12345678, 2'b00, 1'b0, 32'h00000A00, 32'h78787878, 4'b0010, 1'b1};
        vec[11] = '{32'h00000B02, 32'h00007FFF, 2'b01, 1'b0, 32'h00000B00, 32'h7FFF7FFF, 4'b1100, 1'b0};

        rst_n   = 1'b0;
        m_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #12;
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_sready", {31'd0, s_ready}, 32'd1);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_mwdata", m_wdata, 32'h0);
        chk("rst_mbe", {28'd0, m_be}, 32'h0);
        chk("rst_errv", {31'd0, err_valid}, 32'd0);
        chk("rst_erraddr", err_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming table with m_ready=1: each entry is popped the cycle it appears.
        m_ready  = 1'b1;
        last_err = 32'h0;
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (vec[i-1].err) last_err = vec[i-1].addr;
                chk($sformatf("v%0d_errv", i-1), {31'd0, err_valid}, {31'd0, vec[i-1].err});
                chk($sformatf("v%0d_erraddr", i-1), err_addr, last_err);
                chk($sformatf("v%0d_sready", i-1), {31'd0, s_ready}, 32'd1);
                chk($sformatf("v%0d_mvalid", i-1), {31'd0, m_valid}, {31'd0, !vec[i-1].err});
                if (!vec[i-1].err) begin
                    chk($sformatf("v%0d_maddr", i-1), m_addr, vec[i-1].e_addr);
                    chk($sformatf("v%0d_mwdata", i-1), m_wdata, vec[i-1].e_wdata);
                    chk($sformatf("v%0d_mbe", i-1), {28'd0, m_be}, {28'd0, vec[i-1].e_be});
                    chk($sformatf("v%0d_mlossy", i-1), {31'd0, m_lossy}, {31'd0, vec[i-1].e_lossy});
                end
            end
            if (i < NV) drive(1'b1, vec[i].addr, vec[i].data, vec[i].size);
            else drive(1'b0, 32'h0, 32'h0, 2'b00);
        end
        @(negedge clk);
        chk("post_errv", {31'd0, err_valid}, 32'd0);
        chk("post_mvalid", {31'd0, m_valid}, 32'd0);

        // Backpressure: three word stores into a 2-deep buffer.
        m_ready = 1'b0;
        drive(1'b1, 32'h00000100, 32'hAAAA0001, 2'b10);
        @(negedge clk);
        chk("bp_sready1", {31'd0, s_ready}, 32'd1);
        chk_head("bp_a1", 32'h00000100, 32'hAAAA0001);
        drive(1'b1, 32'h00000104, 32'hBBBB0002, 2'b10);
        @(negedge clk);
        chk("bp_sready2", {31'd0, s_ready}, 32'd0);
        chk_head("bp_a2", 32'h00000100, 32'hAAAA0001);
        drive(1'b1, 32'h00000108, 32'hCCCC0003, 2'b10);
        repeat (2) begin
            @(negedge clk);
            chk("bp_full", {31'd0, s_ready}, 32'd0);
            chk_head("bp_hold", 32'h00000100, 32'hAAAA0001);
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_rise", {31'd0, s_ready}, 32'd1);
        chk_head("bp_b", 32'h00000104, 32'hBBBB0002);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk("bp_sready3", {31'd0, s_ready}, 32'd1);
        chk_head("bp_c", 32'h00000108, 32'hCCCC0003);
        @(negedge clk);
        chk("bp_empty", {31'd0, m_valid}, 32'd0);

        // Asynchronous reset with two entries buffered.
        m_ready = 1'b0;
        drive(1'b1, 32'h00000200, 32'h12340000, 2'b10);
        @(negedge clk);
        drive(1'b1, 32'h00000204, 32'h56780000, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk("ar_full", {31'd0, s_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mvalid", {31'd0, m_valid}, 32'd0);
        chk("ar_sready", {31'd0, s_ready}, 32'd1);
        chk("ar_maddr", m_addr, 32'h0);
        chk("ar_erraddr", err_addr, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ar_nostale", {31'd0, m_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
